bus_display_latch: RTL

Capture stage between the processor data bus and the four hex_display decoders on the DE1 board. Latches bus writes into a 4-entry history, then presents one 16-bit entry as four 5-bit digit codes, one per display. The newest entry is shown immediately after capture. With history enabled, the block auto-cycles through stored entries or steps through them on a key press.

---
 rtl/bus_display_latch.sv | 105 ++++++++++
 1 files changed

// File: rtl/bus_display_latch.sv
// Latches processor bus writes and drives four hex digit codes; HISTORY_CYCLE_EN adds a 4-entry history with dwell/step cycling.
// Digits are registered one edge after the capture or slot change that selects them.
module bus_display_latch #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        freeze,
  input  logic        step,
  output logic [4:0]  digit3,
  output logic [4:0]  digit2,
  output logic [4:0]  digit1,
  output logic [4:0]  digit0,
  output logic [1:0]  slot,
  output logic [7:0]  count
);

  logic        capture;
  logic [15:0] shown;

  assign capture = wr_en & ~freeze;

  assign digit3 = {1'b0, shown[15:12]};
  assign digit2 = {1'b0, shown[11:8]};
  assign digit1 = {1'b0, shown[7:4]};
  assign digit0 = {1'b0, shown[3:0]};

`ifdef HISTORY_CYCLE_EN
  localparam int              DCW        = $clog2(DWELL_CYCLES);
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL_CYCLES - 1);

  logic [15:0]    entry [4];
  logic [2:0]     valid;
  logic [1:0]     slot_q;
  logic [DCW-1:0] dwell;
  logic           step_q;
  logic           step_edge;
  logic           cycling;
  logic [1:0]     slot_next;

  assign step_edge = step & ~step_q;
  assign cycling   = (valid >= 3'd2);
  // Wrap back to the newest entry once the oldest valid one has been shown.
  assign slot_next = ({1'b0, slot_q} == valid - 3'd1) ? 2'd0 : slot_q + 2'd1;
  assign slot      = slot_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 4; i++) entry[i] <= '0;
      valid  <= '0;
      slot_q <= '0;
      dwell  <= '0;
      step_q <= 1'b0;
      count  <= '0;
      shown  <= '0;
    end else begin
      step_q <= step;
      shown  <= entry[slot_q];
      if (capture) begin
        entry[0] <= wr_data;
        entry[1] <= entry[0];
        entry[2] <= entry[1];
        entry[3] <= entry[2];
        if (valid != 3'd4) valid <= valid + 3'd1;
        count  <= count + 8'd1;
        slot_q <= '0;
        dwell  <= '0;
      end else if (step_edge && cycling) begin
        slot_q <= slot_next;
        dwell  <= '0;
      end else if (!freeze && cycling) begin
        if (dwell == DWELL_LAST) begin
          dwell  <= '0;
          slot_q <= slot_next;
        end else begin
          dwell <= dwell + DCW'(1);
        end
      end
    end
  end
`else
  logic [15:0] last;
  logic        unused_ok;

  assign slot      = 2'b00;
  assign unused_ok = step ^ (DWELL_CYCLES > 1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last  <= '0;
      count <= '0;
      shown <= '0;
    end else begin
      shown <= last;
      if (capture) begin
        last  <= wr_data;
        count <= count + 8'd1;
      end
    end
  end
`endif

endmodule
